wb_dbg_master: RTL and testbench
================================

WB_DBG_MASTER -- requirements
Module: wb_dbg_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: the number of cycles without an ack after which a bus access aborts.
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-003 i_clk  in  1  system clock; all state changes on the rising edge.
REQ-004 i_rst  in  1  asynchronous active-low reset.
REQ-005 i_rx_data  in  8  command byte from the UART receiver.
REQ-006 i_rx_valid  in  1  i_rx_data is valid.
REQ-007 o_rx_ready  out  1  block accepts a byte this cycle.
REQ-008 o_tx_data  out  8  response byte to the UART transmitter.
REQ-009 o_tx_valid  out  1  o_tx_data is valid.
REQ-010 i_tx_ready  in  1  transmitter accepts the byte this cycle.
REQ-011 o_addr  out  32  Wishbone address.
REQ-012 o_data  out  32  Wishbone write data.
REQ-013 i_data  in  32  Wishbone read data.
REQ-014 o_sel  out  4  byte select; always 4'hF.
REQ-015 o_cyc, o_stb, o_we  out  1 each  Wishbone pipelined master controls.
REQ-016 i_stall, i_ack  in  1 each  Wishbone slave responses.

Function
REQ-017 A byte SHALL transfer only when i_rx_valid and o_rx_ready are both high; a tx byte SHALL transfer only when o_tx_valid and i_tx_ready are both high.
REQ-018 Command frames SHALL be:
- write: 0x57, then 4 address bytes (MSB first), then 4 data bytes (MSB first).
- read: 0x52, then 4 address bytes (MSB first).
REQ-019 In IDLE, any byte other than 0x57 or 0x52 SHALL be consumed and discarded.
REQ-020 States SHALL be IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT and RESP.
REQ-021 Transitions SHALL be:
- IDLE -> ADDR on a command byte.
- ADDR -> DATA (write) or BUS_REQ (read) after the 4th address byte.
- DATA -> BUS_REQ after the 4th data byte.
REQ-022 o_rx_ready SHALL be high only in IDLE, ADDR and DATA.
REQ-023 On entry to BUS_REQ, o_cyc and o_stb SHALL rise in the same cycle; o_stb SHALL hold until a cycle with i_stall low, then drop, moving to BUS_WAIT.
REQ-024 o_cyc SHALL hold until i_ack or timeout; o_addr, o_data and o_we SHALL be stable while o_cyc is high.
REQ-025 i_ack SHALL be honoured in both BUS_REQ and BUS_WAIT, including an ack in the same cycle the strobe is accepted; o_cyc and o_stb SHALL fall the cycle after the ack; i_data SHALL be captured on a read ack.
REQ-026 The timeout counter SHALL start on entry to BUS_REQ and count stall and wait cycles alike; at TIMEOUT_CYCLES without an ack, o_cyc and o_stb SHALL drop and the error response SHALL be sent.
REQ-027 Responses SHALL be:
- write ok: 0x4B.
- read ok: 0x44, then 4 data bytes MSB first.
- timeout: 0x45 only.
REQ-028 In RESP, o_tx_data SHALL stay stable while o_tx_valid is high and unaccepted; after the last byte is accepted, the next state SHALL be IDLE.
REQ-029 An i_ack while o_cyc is low SHALL be ignored.
REQ-030 At most one bus transaction SHALL be outstanding.

Reset
REQ-031 Reset SHALL force IDLE immediately, including mid-frame or mid-bus-cycle, with no clock required.
REQ-032 Reset values SHALL be:
- o_cyc, o_stb, o_we, o_rx_ready, o_tx_valid = 0.
- o_addr, o_data, o_tx_data = 0.
- o_sel = 4'hF.
REQ-033 A partial frame or pending response SHALL be discarded on reset.

Structure
REQ-034 A shared package wb_dbg_pkg SHALL hold the state enum, the command bytes 0x57/0x52 and the response bytes 0x4B/0x44/0x45.
REQ-035 The design SHALL be a single module with no sub-module; the byte-index counter and the timeout counter are local.

Verification
REQ-036 Write: send 57 02 00 00 04 00 00 AB CD with slave ack 1 cycle after strobe -> one strobe, o_addr=0x02000004, o_data=0x0000ABCD, o_we=1, then tx byte 4B.
REQ-037 Read with stall: send 52 00 00 00 10, i_stall high 3 cycles, i_data=0xDEADBEEF on ack -> o_stb high exactly 4 cycles, tx bytes 44 DE AD BE EF.
REQ-038 Timeout: read with i_ack never asserted, TIMEOUT_CYCLES=16 -> o_cyc drops after 16 cycles, tx byte 45 only.
REQ-039 Back-pressure: i_tx_ready low 5 cycles during a read response -> o_tx_data holds each byte and none is lost or duplicated.
REQ-040 Reset mid-bus: assert i_rst low while o_cyc=1 -> o_cyc and o_stb are 0 in the same cycle; after release, the block is IDLE and the bytes FF 57 followed by a full write frame produce 4B.

Source files
------------

// File: rtl/wb_dbg_pkg.sv
// Shared types and protocol bytes for the UART-to-Wishbone debug master.
package wb_dbg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StBusReq,
        StBusWait,
        StResp
    } state_e;

    localparam logic [7:0] CmdWrite   = 8'h57;
    localparam logic [7:0] CmdRead    = 8'h52;
    localparam logic [7:0] RspWriteOk = 8'h4B;
    localparam logic [7:0] RspReadOk  = 8'h44;
    localparam logic [7:0] RspTimeout = 8'h45;

endpackage

// File: rtl/wb_dbg_master.sv
// Byte-stream command decoder that issues single Wishbone pipelined accesses
// and streams back a status byte (plus read data) to a UART transmitter.
module wb_dbg_master
    import wb_dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [31:0] o_addr,
    output logic [31:0] o_data,
    input  logic [31:0] i_data,
    output logic [3:0]  o_sel,
    output logic        o_cyc,
    output logic        o_stb,
    output logic        o_we,
    input  logic        i_stall,
    input  logic        i_ack
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES) + 1;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     resp_q, resp_d;
    logic [2:0]      resp_cnt_q, resp_cnt_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic            we_q, we_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic [TmoW-1:0] tmo_q, tmo_d;

    logic rx_fire;
    logic tx_fire;
    logic tmo_hit;

    // Gated by reset so the handshake is low while the block is held in reset.
    assign o_rx_ready = i_rst & ((state_q == StIdle) | (state_q == StAddr) |
                                 (state_q == StData));
    assign rx_fire    = i_rx_valid & o_rx_ready;
    assign tx_fire    = tx_valid_q & i_tx_ready;
    assign tmo_hit    = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
            resp_cnt_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            resp_cnt_q <= resp_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;
        resp_cnt_d = resp_cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        we_d       = we_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        tmo_d      = tmo_q;

        case (state_q)
            StIdle: begin
                if (rx_fire) begin
                    idx_d = '0;
                    if (i_rx_data == CmdWrite) begin
                        we_d    = 1'b1;
                        state_d = StAddr;
                    end else if (i_rx_data == CmdRead) begin
                        we_d    = 1'b0;
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                if (rx_fire) begin
                    addr_d = {addr_q[23:0], i_rx_data};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (we_q) begin
                            state_d = StData;
                        end else begin
                            state_d = StBusReq;
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            tmo_d   = '0;
                        end
                    end
                end
            end
            StData: begin
                if (rx_fire) begin
                    wdata_d = {wdata_q[23:0], i_rx_data};
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = StBusReq;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        tmo_d   = '0;
                    end
                end
            end
            StBusReq, StBusWait: begin
                tmo_d = tmo_q + TmoW'(1);
                // An ack while still strobing implies the strobe was taken.
                if (i_ack) begin
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    tx_valid_d = 1'b1;
                    state_d    = StResp;
                    if (we_q) begin
                        tx_data_d  = RspWriteOk;
                        resp_cnt_d = 3'd0;
                    end else begin
                        tx_data_d  = RspReadOk;
                        resp_d     = i_data;
                        resp_cnt_d = 3'd4;
                    end
                end else if (tmo_hit) begin
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = RspTimeout;
                    resp_cnt_d = 3'd0;
                    state_d    = StResp;
                end else if (state_q == StBusReq && !i_stall) begin
                    stb_d   = 1'b0;
                    state_d = StBusWait;
                end
            end
            StResp: begin
                if (tx_fire) begin
                    if (resp_cnt_q == 3'd0) begin
                        tx_valid_d = 1'b0;
                        state_d    = StIdle;
                    end else begin
                        tx_data_d  = resp_q[31:24];
                        resp_d     = {resp_q[23:0], 8'h00};
                        resp_cnt_d = resp_cnt_q - 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_addr     = addr_q;
    assign o_data     = wdata_q;
    assign o_sel      = 4'hF;
    assign o_cyc      = cyc_q;
    assign o_stb      = stb_q;
    assign o_we       = we_q;

endmodule

// File: tb/tb_wb_dbg_master.sv
// Directed bench for wb_dbg_master: drives command frames, emulates a Wishbone
// slave and checks response bytes against a queue of expected bytes.
module tb_wb_dbg_master;

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [31:0] o_addr;
    logic [31:0] o_data;
    logic [31:0] i_data;
    logic [3:0]  o_sel;
    logic        o_cyc;
    logic        o_stb;
    logic        o_we;
    logic        i_stall;
    logic        i_ack;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] cap_addr;
    logic [31:0] cap_data;
    logic        cap_we;
    int          stb_n;
    int          cyc_n;

    wb_dbg_master #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_rx_ready (o_rx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_addr     (o_addr),
        .o_data     (o_data),
        .i_data     (i_data),
        .o_sel      (o_sel),
        .o_cyc      (o_cyc),
        .o_stb      (o_stb),
        .o_we       (o_we),
        .i_stall    (i_stall),
        .i_ack      (i_ack)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        while (!o_rx_ready && k < 50) begin
            @(negedge i_clk);
            k++;
        end
        check("rx_accept", o_rx_ready, 1'b1);
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                            input bit with_data);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8]);
        if (with_data) begin
            for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8]);
        end
    endtask

    // Slave model: stall for a number of cycles, then accept and ack after ack_lat cycles.
    task automatic bus_serve(input int stalls, input int ack_lat, input bit do_ack,
                             input logic [31:0] rd);
        int  budget;
        int  wait_n;
        bit  accepted;
        budget   = 0;
        wait_n   = 0;
        accepted = 1'b0;
        stb_n    = 0;
        cyc_n    = 0;
        i_data   = rd;
        while (o_cyc && budget < 200) begin
            cyc_n++;
            if (o_stb) stb_n++;
            i_ack   = 1'b0;
            i_stall = 1'b0;
            if (!accepted) begin
                if (stalls > 0) begin
                    i_stall = 1'b1;
                    stalls--;
                end else begin
                    accepted = 1'b1;
                    cap_addr = o_addr;
                    cap_data = o_data;
                    cap_we   = o_we;
                    wait_n   = ack_lat;
                    if (do_ack && wait_n == 0) i_ack = 1'b1;
                end
            end else if (do_ack) begin
                wait_n--;
                if (wait_n == 0) i_ack = 1'b1;
            end
            @(negedge i_clk);
            budget++;
        end
        i_ack   = 1'b0;
        i_stall = 1'b0;
        check("bus_done", o_cyc, 1'b0);
    endtask

    task automatic get_resp(input int n, input bit bp);
        int         got;
        int         k;
        bit         held;
        logic [7:0] hold_v;
        logic [7:0] e;
        got  = 0;
        k    = 0;
        held = 1'b0;
        hold_v = '0;
        while (got < n && k < 100) begin
            i_tx_ready = !(bp && k >= 2 && k < 7);
            if (held) check("tx_hold", o_tx_data, hold_v);
            held = 1'b0;
            if (o_tx_valid && i_tx_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("tx_byte", o_tx_data, e);
                got++;
            end else if (o_tx_valid) begin
                held   = 1'b1;
                hold_v = o_tx_data;
            end
            @(negedge i_clk);
            k++;
        end
        i_tx_ready = 1'b0;
        check("tx_count", got, n);
        check("tx_idle_valid", o_tx_valid, 1'b0);
        check("tx_idle_ready", o_rx_ready, 1'b1);
    endtask

    initial begin
        i_rst      = 1'b0;
        i_rx_data  = '0;
        i_rx_valid = 1'b0;
        i_tx_ready = 1'b0;
        i_data     = '0;
        i_stall    = 1'b0;
        i_ack      = 1'b0;

        #12;
        check("rst_cyc", o_cyc, 1'b0);
        check("rst_stb", o_stb, 1'b0);
        check("rst_we", o_we, 1'b0);
        check("rst_rx_ready", o_rx_ready, 1'b0);
        check("rst_tx_valid", o_tx_valid, 1'b0);
        check("rst_addr", o_addr, 32'h0);
        check("rst_data", o_data, 32'h0);
        check("rst_tx_data", o_tx_data, 8'h00);
        check("rst_sel", o_sel, 4'hF);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("idle_ready", o_rx_ready, 1'b1);

        // Write, ack one cycle after the strobe is taken.
        exp_q.push_back(8'h4B);
        send_cmd(8'h57, 32'h0200_0004, 32'h0000_ABCD, 1'b1);
        bus_serve(0, 1, 1'b1, 32'h0);
        check("wr_stb_n", stb_n, 1);
        check("wr_cyc_n", cyc_n, 2);
        check("wr_addr", cap_addr, 32'h0200_0004);
        check("wr_data", cap_data, 32'h0000_ABCD);
        check("wr_we", cap_we, 1'b1);
        get_resp(1, 1'b0);

        // Read with three stalled strobe cycles.
        exp_q.push_back(8'h44);
        exp_q.push_back(8'hDE);
        exp_q.push_back(8'hAD);
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
        send_cmd(8'h52, 32'h0000_0010, 32'h0, 1'b0);
        bus_serve(3, 1, 1'b1, 32'hDEAD_BEEF);
        check("rd_stb_n", stb_n, 4);
        check("rd_addr", cap_addr, 32'h0000_0010);
        check("rd_we", cap_we, 1'b0);
        get_resp(5, 1'b0);

        // Read that is never acked.
        exp_q.push_back(8'h45);
        send_cmd(8'h52, 32'h0000_0020, 32'h0, 1'b0);
        bus_serve(0, 0, 1'b0, 32'h0);
        check("tmo_cyc_n", cyc_n, 16);
        check("tmo_stb_n", stb_n, 1);
        get_resp(1, 1'b0);

        // Read response under transmitter back-pressure.
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h56);
        exp_q.push_back(8'h78);
        send_cmd(8'h52, 32'h0000_0030, 32'h0, 1'b0);
        bus_serve(1, 2, 1'b1, 32'h1234_5678);
        check("bp_addr", cap_addr, 32'h0000_0030);
        get_resp(5, 1'b1);

        // Write acked in the same cycle the strobe is accepted.
        exp_q.push_back(8'h4B);
        send_cmd(8'h57, 32'hCAFE_0000, 32'h5555_AAAA, 1'b1);
        bus_serve(0, 0, 1'b1, 32'h0);
        check("ack0_cyc_n", cyc_n, 1);
        check("ack0_data", cap_data, 32'h5555_AAAA);
        get_resp(1, 1'b0);

        // Stray ack while idle must not start anything.
        i_ack = 1'b1;
        repeat (3) @(negedge i_clk);
        check("stray_cyc", o_cyc, 1'b0);
        check("stray_tx", o_tx_valid, 1'b0);
        i_ack = 1'b0;

        // Reset asserted in the middle of a bus cycle.
        send_cmd(8'h52, 32'h0000_0040, 32'h0, 1'b0);
        i_stall = 1'b1;
        repeat (2) @(negedge i_clk);
        check("mid_cyc_before", o_cyc, 1'b1);
        #2 i_rst = 1'b0;
        #1;
        check("mid_cyc", o_cyc, 1'b0);
        check("mid_stb", o_stb, 1'b0);
        check("mid_tx_valid", o_tx_valid, 1'b0);
        @(negedge i_clk);
        i_rst   = 1'b1;
        i_stall = 1'b0;
        @(negedge i_clk);
        check("post_rst_ready", o_rx_ready, 1'b1);
        exp_q.push_back(8'h4B);
        send_byte(8'hFF);
        send_cmd(8'h57, 32'h0000_0100, 32'h0BAD_F00D, 1'b1);
        bus_serve(0, 1, 1'b1, 32'h0);
        check("post_addr", cap_addr, 32'h0000_0100);
        check("post_data", cap_data, 32'h0BAD_F00D);
        check("post_we", cap_we, 1'b1);
        get_resp(1, 1'b0);

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
